alu_cmp_seq: RTL

Sequential magnitude-comparator controller for the ALU compare path. It latches two WIDTH-bit operands on a start handshake and scans them one bit per cycle from MSB to LSB. The per-bit compare result is OR-chained with the decision from the upper bits, and the scan stops at the first differing bit. It reports gt/lt/eq with a one-cycle done pulse and supports unsigned and two's-complement signed compares.

---
 rtl/alu_pkg.sv | 15 +
 rtl/cmp_bit_cell.sv | 25 ++
 rtl/alu_cmp_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU compare path: FSM states and the {gt,lt,eq}
// result codes.
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One-hot result selects packed as {gt, lt, eq}
    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit slice of the magnitude compare chain. It reports a new
// decision only when no upper bit has already decided.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic msb_signed,
    input  logic upper_decided,
    output logic bit_gt,
    output logic bit_lt,
    output logic decided_out
);

    logic differ;
    logic a_wins;

    always_comb begin
        differ      = a_bit ^ b_bit;
        // On a signed MSB the set bit marks the negative (smaller) operand
        a_wins      = msb_signed ? b_bit : a_bit;
        bit_gt      = differ & ~upper_decided & a_wins;
        bit_lt      = differ & ~upper_decided & ~a_wins;
        decided_out = differ | upper_decided;
    end

endmodule

// File: rtl/alu_cmp_seq.sv
// Bit-serial magnitude comparator: latches operands on start, scans MSB to
// LSB through one shared cmp_bit_cell and reports gt/lt/eq with a done pulse.
module alu_cmp_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     is_signed,
    input  logic [WIDTH-1:0]         op_a,
    input  logic [WIDTH-1:0]         op_b,
    output logic                     busy,
    output logic                     done,
    output logic                     gt,
    output logic                     lt,
    output logic                     eq,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic [2:0]       res_q, res_d;

    logic cell_gt;
    logic cell_lt;
    logic cell_decided;
    logic msb_signed;

    assign msb_signed = signed_q && (idx_q == IDX_MSB);

    cmp_bit_cell u_cell (
        .a_bit        (a_q[idx_q]),
        .b_bit        (b_q[idx_q]),
        .msb_signed   (msb_signed),
        .upper_decided(decided_q),
        .bit_gt       (cell_gt),
        .bit_lt       (cell_lt),
        .decided_out  (cell_decided)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        res_d     = res_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    signed_d  = is_signed;
                    idx_d     = IDX_MSB;
                    decided_d = 1'b0;
                    res_d     = CMP_NONE;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    decided_d = 1'b0;
                    res_d     = CMP_NONE;
                end else begin
                    if (cell_gt) begin
                        res_d = CMP_GT;
                    end else if (cell_lt) begin
                        res_d = CMP_LT;
                    end
                    decided_d = cell_decided;
                    // With early exit, decided here can only mean this bit differs
                    if (EARLY_EXIT && cell_decided) begin
                        state_d = ST_DONE;
                    end else if (idx_q == '0) begin
                        if (!cell_decided) begin
                            res_d = CMP_EQ;
                        end
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx_q     <= IDX_MSB;
            decided_q <= 1'b0;
            res_q     <= CMP_NONE;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            res_q     <= res_d;
        end
    end

    assign busy    = (state_q == ST_SCAN);
    assign done    = (state_q == ST_DONE);
    assign gt      = res_q[2];
    assign lt      = res_q[1];
    assign eq      = res_q[0];
    assign bit_idx = idx_q;

endmodule
